fire_dispatch_arbiter: RTL

Sits in front of the fire dispatcher and shares its single axon-range input between two fire sources: source 0 (neuron/axon path) and source 1 (host input injection). Each source pushes `{syn_start, syn_end}` ranges into its own small FIFO. A round-robin arbiter forwards them one at a time over the dispatcher's valid/ready handshake. The block also reports a combined, step-level `step_done`.

---
 rtl/fire_dispatch_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fire_dispatch_arbiter.sv
// Two-source round-robin front end for the fire dispatcher: per-source range FIFOs, one output stage, step-level idle.
// Optional macro UCASPIAN_DISPATCH_RANGE_CHECK_EN: drop descending ranges at grant time and count them.
module fire_dispatch_arbiter #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 12
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_src0_vld,
   input  logic              i_src1_vld,
   output logic              o_src0_rdy,
   output logic              o_src1_rdy,
   input  logic [ADDR_W-1:0] i_src0_start,
   input  logic [ADDR_W-1:0] i_src1_start,
   input  logic [ADDR_W-1:0] i_src0_end,
   input  logic [ADDR_W-1:0] i_src1_end,
   output logic              o_dsp_vld,
   input  logic              i_dsp_rdy,
   output logic [ADDR_W-1:0] o_dsp_start,
   output logic [ADDR_W-1:0] o_dsp_end,
   input  logic              i_dsp_step_done,
   output logic              o_step_done,
   output logic              o_range_err,
   output logic [7:0]        o_err_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] r_mem_start [2][DEPTH];
   logic [ADDR_W-1:0] r_mem_end   [2][DEPTH];
   logic [PTR_W-1:0]  r_wptr [2];
   logic [PTR_W-1:0]  r_rptr [2];
   logic [CNT_W-1:0]  r_cnt  [2];
   logic              r_last_grant;
   logic              r_dsp_vld;
   logic [ADDR_W-1:0] r_dsp_start;
   logic [ADDR_W-1:0] r_dsp_end;
   logic              r_step_done;

   logic [ADDR_W-1:0] w_in_start [2];
   logic [ADDR_W-1:0] w_in_end   [2];
   logic [1:0]        w_vld;
   logic [1:0]        w_rdy;
   logic [1:0]        w_push;
   logic [1:0]        w_pop;
   logic [1:0]        w_ne;
   logic              w_slot;
   logic              w_grant;
   logic              w_sel;
   logic              w_bad;
   logic              w_load;
   logic [ADDR_W-1:0] w_head_start;
   logic [ADDR_W-1:0] w_head_end;

   assign w_in_start[0] = i_src0_start;
   assign w_in_start[1] = i_src1_start;
   assign w_in_end[0]   = i_src0_end;
   assign w_in_end[1]   = i_src1_end;
   assign w_vld         = {i_src1_vld, i_src0_vld};

   // Accept, arbitration and load decisions from start-of-cycle occupancy.
   always_comb begin
      w_rdy  = 2'b00;
      w_push = 2'b00;
      w_pop  = 2'b00;
      w_ne   = 2'b00;
      for (int k = 0; k < 2; k++) begin
         w_ne[k]   = (r_cnt[k] != '0);
         w_rdy[k]  = i_enable && !i_reset && (r_cnt[k] != FULL_CNT);
         w_push[k] = w_vld[k] && w_rdy[k];
      end
      w_slot  = i_enable && (!r_dsp_vld || i_dsp_rdy);
      w_grant = w_slot && (w_ne[0] || w_ne[1]);
      if (w_ne[0] && w_ne[1]) begin
         w_sel = !r_last_grant;
      end else begin
         w_sel = w_ne[1];
      end
      w_head_start = r_mem_start[w_sel][r_rptr[w_sel]];
      w_head_end   = r_mem_end[w_sel][r_rptr[w_sel]];
`ifdef UCASPIAN_DISPATCH_RANGE_CHECK_EN
      w_bad = w_grant && (w_head_end < w_head_start);
`else
      w_bad = 1'b0;
`endif
      w_load = w_grant && !w_bad;
      for (int k = 0; k < 2; k++) begin
         w_pop[k] = w_grant && (w_sel == 1'(k));
      end
   end

   assign o_src0_rdy = w_rdy[0];
   assign o_src1_rdy = w_rdy[1];

   // Per-source circular FIFOs; a pop never frees room for a same-cycle push.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < 2; k++) begin
            r_wptr[k] <= '0;
            r_rptr[k] <= '0;
            r_cnt[k]  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               r_mem_start[k][j] <= '0;
               r_mem_end[k][j]   <= '0;
            end
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (w_push[k]) begin
               r_mem_start[k][r_wptr[k]] <= w_in_start[k];
               r_mem_end[k][r_wptr[k]]   <= w_in_end[k];
               r_wptr[k] <= r_wptr[k] + 1'b1;
            end
            if (w_pop[k]) begin
               r_rptr[k] <= r_rptr[k] + 1'b1;
            end
            r_cnt[k] <= r_cnt[k] + CNT_W'(w_push[k]) - CNT_W'(w_pop[k]);
         end
      end
   end

   // Output stage, grant history and registered idle flag.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_dsp_vld    <= 1'b0;
         r_dsp_start  <= '0;
         r_dsp_end    <= '0;
         r_last_grant <= 1'b1;
         r_step_done  <= 1'b1;
      end else begin
         if (w_load) begin
            r_dsp_vld   <= 1'b1;
            r_dsp_start <= w_head_start;
            r_dsp_end   <= w_head_end;
         end else if (r_dsp_vld && i_dsp_rdy) begin
            r_dsp_vld <= 1'b0;
         end
         if (w_grant) begin
            r_last_grant <= w_sel;
         end
         r_step_done <= (r_cnt[0] == '0) && (r_cnt[1] == '0) && !r_dsp_vld &&
                        !i_src0_vld && !i_src1_vld && i_dsp_step_done;
      end
   end

   assign o_dsp_vld   = r_dsp_vld;
   assign o_dsp_start = r_dsp_start;
   assign o_dsp_end   = r_dsp_end;
   assign o_step_done = r_step_done;

`ifdef UCASPIAN_DISPATCH_RANGE_CHECK_EN
   logic       r_range_err;
   logic [7:0] r_err_cnt;

   // Sticky error flag and saturating drop counter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_range_err <= 1'b0;
         r_err_cnt   <= 8'd0;
      end else if (w_bad) begin
         r_range_err <= 1'b1;
         if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign o_range_err = r_range_err;
   assign o_err_cnt   = r_err_cnt;
`else
   assign o_range_err = 1'b0;
   assign o_err_cnt   = 8'd0;
`endif
endmodule
